// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// source-count limits and the claim record layout.
package irq_pkg;

    localparam int N_SRC_MAX = 16;
    localparam int ID_W      = 5;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_MODE     = 3'd2;
    localparam logic [2:0] REG_CLAIM    = 3'd3;
    localparam logic [2:0] REG_COMPLETE = 3'd4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } claim_t;

    // CLAIM register read layout: valid in bit 31, id in the low bits.
    function automatic logic [31:0] claim_word(input claim_t c);
        return {c.valid, 26'b0, c.id};
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-set-bit finder. Index 0 is the highest priority, so the
// lowest set bit is the winner. o_idx is 0 when nothing is set.
module prio_enc #(
    parameter int W = 6
) (
    input  logic [W-1:0] i_vec,
    output logic         o_found,
    output logic [4:0]   o_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = 5'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level capture, masking, fixed
// priority with nesting through an in-service vector, and a small
// memory-mapped window for software claim/complete.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:2]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src,
    output logic             irq
);

    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_isr;
    claim_t           r_last_claim;

    logic             w_isr_found;
    logic [4:0]       w_isr_idx;
    logic [4:0]       w_cur;
    logic [N_SRC-1:0] w_eligible;
    logic             w_el_found;
    logic [4:0]       w_el_idx;

    logic             w_wr_pending;
    logic             w_wr_mask;
    logic             w_wr_mode;
    logic             w_wr_claim;
    logic             w_wr_complete;
    logic             w_claim_hit;

    logic [N_SRC-1:0] w_claim_onehot;
    logic [N_SRC-1:0] w_complete_onehot;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pending_next;
    logic [N_SRC-1:0] w_isr_next;

    // Address bits above the decoded window and data bits above the
    // source count carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

    // Current service level: the highest-priority source being serviced.
    prio_enc #(.W(N_SRC)) u_cur_enc (
        .i_vec   (r_isr),
        .o_found (w_isr_found),
        .o_idx   (w_isr_idx)
    );
    assign w_cur = w_isr_found ? w_isr_idx : 5'(N_SRC);

    // Winner among sources allowed to preempt the current level.
    prio_enc #(.W(N_SRC)) u_claim_enc (
        .i_vec   (w_eligible),
        .o_found (w_el_found),
        .o_idx   (w_el_idx)
    );

    assign w_wr_pending  = WE && (Addr[4:2] == REG_PENDING);
    assign w_wr_mask     = WE && (Addr[4:2] == REG_MASK);
    assign w_wr_mode     = WE && (Addr[4:2] == REG_MODE);
    assign w_wr_claim    = WE && (Addr[4:2] == REG_CLAIM);
    assign w_wr_complete = WE && (Addr[4:2] == REG_COMPLETE);
    assign w_claim_hit   = w_wr_claim && w_el_found;

    assign w_rise = src & ~r_src_q;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            // Only strictly higher-priority sources may nest above the current level.
            assign w_eligible[gi] = r_pending[gi] & r_mask[gi] & ~r_isr[gi]
                                    & (5'(gi) < w_cur);

            assign w_claim_onehot[gi]    = w_claim_hit && (w_el_idx == 5'(gi));
            // Ids at or beyond N_SRC match no bit, so they are dropped naturally.
            assign w_complete_onehot[gi] = w_wr_complete && (Din[4:0] == 5'(gi));

            assign w_clr[gi] = (w_wr_pending & Din[gi]) | w_claim_onehot[gi];

            // Edge mode: a new edge beats a same-cycle clear. Level mode tracks src.
            assign w_pending_next[gi] = r_mode[gi]
                                      ? (w_rise[gi] | (r_pending[gi] & ~w_clr[gi]))
                                      : src[gi];
        end
    endgenerate

    // Claim and complete cannot coincide (one register write per cycle).
    assign w_isr_next = (r_isr | w_claim_onehot) & ~w_complete_onehot;

    assign irq = |w_eligible;

    // Register state: sampling, software writes, claim/complete bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_mode       <= '1;
            r_isr        <= '0;
            r_last_claim <= '0;
        end else begin
            r_src_q   <= src;
            r_pending <= w_pending_next;
            r_isr     <= w_isr_next;
            if (w_wr_mask) begin
                r_mask <= Din[N_SRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= Din[N_SRC-1:0];
            end
            if (w_wr_claim) begin
                r_last_claim.valid <= w_el_found;
                r_last_claim.id    <= w_el_found ? w_el_idx : 5'd0;
            end
        end
    end

    // Read mux over the register window; unused offsets read zero.
    always_comb begin
        Dout = 32'd0;
        case (Addr[4:2])
            REG_PENDING:  Dout = 32'(r_pending);
            REG_MASK:     Dout = 32'(r_mask);
            REG_MODE:     Dout = 32'(r_mode);
            REG_CLAIM:    Dout = claim_word(r_last_claim);
            REG_COMPLETE: Dout = 32'(r_isr);
            default:      Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:2]   Addr;
    logic          WE;
    logic [31:0]   Din;
    logic [31:0]   Dout;
    logic [N-1:0]  src;
    logic          irq;

    always #10 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .src   (src),
        .irq   (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit [N-1:0] m_pend, m_mask, m_mode, m_isr, m_srcq;
    bit         m_cv;
    int         m_cid;

    // Lowest eligible source under the priority/nesting rules, -1 if none.
    function automatic int first_elig();
        int cur = N;
        for (int i = N - 1; i >= 0; i--) if (m_isr[i]) cur = i;
        for (int i = 0; i < cur; i++)
            if (m_pend[i] && m_mask[i] && !m_isr[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        Addr = 30'($urandom);
        Addr[4:2] = 3'(a);
        #1;
        d = Dout;
    endtask

    task automatic expect_reg(input string tag, input int a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Compare irq and every register against the model.
    task automatic check_model(input string tag);
        logic [31:0] d;
        chk({tag, ":irq"}, 32'(irq), 32'(first_elig() >= 0));
        rd(0, d); chk({tag, ":pend"}, d, 32'(m_pend));
        rd(1, d); chk({tag, ":mask"}, d, 32'(m_mask));
        rd(2, d); chk({tag, ":mode"}, d, 32'(m_mode));
        rd(3, d); chk({tag, ":claim"}, d, {m_cv, 26'b0, 5'(m_cid)});
        rd(4, d); chk({tag, ":isr"}, d, 32'(m_isr));
        rd(5 + int'($urandom_range(0, 2)), d); chk({tag, ":hole"}, d, 32'd0);
    endtask

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_mode = '1; m_isr = '0; m_srcq = '0;
        m_cv = 1'b0; m_cid = 0;
    endfunction

    // One clock cycle with the given bus write (or idle) and source levels.
    task automatic step(input bit we, input int a, input logic [31:0] din, input logic [N-1:0] s);
        int claimed = -1;
        int e;
        bit [N-1:0] np;
        @(negedge clk);
        WE = we; Din = din; src = s;
        Addr = 30'($urandom); Addr[4:2] = 3'(a);
        e = first_elig();
        if (we && a == 3) begin
            if (e >= 0) begin
                claimed = e; m_cv = 1'b1; m_cid = e;
            end else begin
                m_cv = 1'b0; m_cid = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                bit rise = s[i] && !m_srcq[i];
                bit clr  = (we && a == 0 && din[i]) || (claimed == i);
                np[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end else begin
                np[i] = s[i];
            end
        end
        m_pend = np;
        m_srcq = s;
        if (claimed >= 0) m_isr[claimed] = 1'b1;
        if (we && a == 4 && din[4:0] < 5'(N)) m_isr[din[4:0]] = 1'b0;
        if (we && a == 1) m_mask = din[N-1:0];
        if (we && a == 2) m_mode = din[N-1:0];
        @(posedge clk);
        #1;
        WE = 1'b0;
        $display("step we=%0d reg=%0d din=%h src=%b -> irq=%0b", we, a, din, s, irq);
    endtask

    // Two reset cycles with a write attempted alongside to show reset wins.
    task automatic do_reset(input logic [N-1:0] s);
        @(negedge clk);
        reset = 1'b1; src = s; WE = 1'b1; Addr = '0; Addr[4:2] = 3'd1; Din = '1;
        @(posedge clk);
        @(negedge clk);
        Addr[4:2] = 3'd3;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; WE = 1'b0;
        model_reset();
        #1;
        $display("reset applied, src=%b", s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0; src = '0;
        do_reset('0);
        check_model("reset");
        expect_reg("reset_mode", 2, 32'h3F);
        chk("reset_irq", 32'(irq), 32'd0);

        // Edge capture and claim
        step(1, 1, 32'h3F, 6'h00);
        step(0, 0, 0, 6'h04);
        expect_reg("edge_pend", 0, 32'h04);
        chk("edge_irq", 32'(irq), 32'd1);
        check_model("edge");
        step(1, 3, 0, 6'h04);
        expect_reg("edge_claim", 3, 32'h8000_0002);
        expect_reg("edge_pend_clr", 0, 32'h0);
        chk("edge_irq_clr", 32'(irq), 32'd0);
        step(1, 4, 2, 6'h00);
        check_model("edge_done");

        // Nesting
        step(0, 0, 0, 6'h08);
        step(1, 3, 0, 6'h08);
        step(0, 0, 0, 6'h28);
        chk("nest_blocked", 32'(irq), 32'd0);
        step(0, 0, 0, 6'h2A);
        chk("nest_irq", 32'(irq), 32'd1);
        step(1, 3, 0, 6'h2A);
        expect_reg("nest_isr", 4, 32'h0A);
        expect_reg("nest_claim", 3, 32'h8000_0001);
        step(1, 4, 1, 6'h2A);
        expect_reg("nest_isr1", 4, 32'h08);
        expect_reg("nest_pend5", 0, 32'h20);
        chk("nest_irq_blk", 32'(irq), 32'd0);
        step(1, 4, 3, 6'h00);
        chk("nest_resume", 32'(irq), 32'd1);
        step(1, 3, 0, 6'h00);
        expect_reg("nest_claim5", 3, 32'h8000_0005);
        step(1, 4, 5, 6'h00);
        check_model("nest");

        // Level mode
        step(1, 2, 32'h3E, 6'h00);
        step(0, 0, 0, 6'h01);
        step(1, 0, 32'h01, 6'h01);
        expect_reg("lvl_w1c", 0, 32'h01);
        step(1, 3, 0, 6'h01);
        expect_reg("lvl_claim", 3, 32'h8000_0000);
        step(0, 0, 0, 6'h00);
        step(1, 4, 0, 6'h00);
        expect_reg("lvl_pend", 0, 32'h0);
        chk("lvl_irq", 32'(irq), 32'd0);
        step(1, 2, 32'h3F, 6'h00);
        check_model("level");

        // Set/clear collision
        step(0, 0, 0, 6'h10);
        step(0, 0, 0, 6'h00);
        step(1, 0, 32'h10, 6'h10);
        expect_reg("coll_pend", 0, 32'h10);
        step(1, 0, 32'h10, 6'h10);
        expect_reg("coll_w1c", 0, 32'h00);
        step(0, 0, 0, 6'h00);
        check_model("collision");

        // Empty claim
        step(1, 1, 0, 6'h03);
        step(0, 0, 0, 6'h00);
        chk("empty_irq", 32'(irq), 32'd0);
        step(1, 3, 0, 6'h00);
        expect_reg("empty_claim", 3, 32'h0);
        expect_reg("empty_isr", 4, 32'h0);
        step(1, 0, 32'h03, 6'h00);
        check_model("empty");

        // Reset mid-service, with src held through reset
        step(1, 1, 32'h3F, 6'h00);
        step(0, 0, 0, 6'h01);
        step(1, 3, 0, 6'h01);
        expect_reg("rst_isr_pre", 4, 32'h01);
        do_reset(6'h01);
        check_model("rst_mid");
        chk("rst_irq", 32'(irq), 32'd0);
        step(0, 0, 0, 6'h01);
        expect_reg("rst_edge", 0, 32'h01);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int r = $urandom_range(0, 99);
            logic [N-1:0] s = src;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
            if (r < 2) begin
                do_reset(s);
            end else if (r < 40) begin
                step(0, 0, 0, s);
            end else if (r < 50) begin
                step(1, 1, $urandom | 32'h0000_0030, s);
            end else if (r < 70) begin
                step(1, 3, $urandom, s);
            end else if (r < 85) begin
                step(1, 4, ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7)), s);
            end else begin
                step(1, $urandom_range(0, 7), $urandom, s);
            end
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
